uart_tx: RTL
============

# uart_tx

Byte-wide UART transmitter that sits directly downstream of the counter stage and serializes each 8-bit value it is handed onto a single asynchronous serial line. It accepts a byte over a valid/ready handshake, generates its own bit timing from the system clock, and emits a standard 8N1 frame (start, 8 data bits LSB first, stop). The top level connects `counter_out` to `data_in` so counter values can be observed on a host terminal.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; legal range ≥ 2.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `data_in` input, 8 bits: byte to transmit. Sampled only on an accept cycle.
- `valid` input, 1 bit: `data_in` is valid.
- `ready` output, 1 bit: block can accept a byte this cycle.
- `tx` output, 1 bit: serial line. Idle level is 1.
- `busy` output, 1 bit: a frame is in progress. It is the inverse of `ready`.

## Operation
- Accept occurs when `valid && ready` at a rising edge. On accept, `data_in` is captured into a shift register. Later changes on `data_in` have no effect on the frame.
- The FSM has five states: IDLE, START, DATA, PARITY and STOP. PARITY exists only with the configuration macro.
- IDLE: `tx`=1, `ready`=1. On accept, the next state is START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with the bit index at 0.
- DATA: `tx`=shreg[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7, the next state is PARITY if enabled, otherwise STOP.
- PARITY: `tx` = XOR of the captured byte (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- `valid` asserted outside IDLE is ignored. Nothing is captured or queued, and the upstream stage must hold `valid` until `ready`.
- Bit counter: 3 bits, counting 0..7.
- Cycle counter: $clog2(CLKS_PER_BIT) bits. It is cleared on accept and at every bit boundary, so bit timing is aligned to the accept edge and does not free-run.
- Reset values: `tx`=1, `ready`=1, `busy`=0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the frame is aborted, and the outputs take their reset values on the cycle after the `rst` edge. No partial stop bit is generated.
- `rst` and `valid` asserted together: reset wins and nothing is accepted.

## Timing
- The accept edge is edge k. `tx` falls on the cycle after edge k and remains low for CLKS_PER_BIT cycles.
- Data bit i occupies cycles k+1+N(1+i) through k+N(2+i), where N is CLKS_PER_BIT.
- The stop bit ends at cycle k+10N without parity, or k+11N with parity.
- `ready` returns to 1 on the first cycle after the stop bit.
- Back-to-back transfer: if `valid` is held, the next accept happens on that first `ready` cycle. Frames are therefore separated by exactly 1 idle cycle of `tx`=1.
- Latency from accept to the start-bit edge is 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit is inserted between bit 7 and the stop bit. The frame is 11 bits (8E1).
- `UART_TX_PARITY_EN` undefined: the PARITY state and the parity logic are absent. The frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg` holds:
  - the state enum typedef `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the constant `UART_DATA_BITS`=8;
  - the idle and stop line-level constants.
- Sub-module `uart_bit_timer`: a counter with a synchronous clear input and a one-cycle `bit_done` pulse every CLKS_PER_BIT cycles. It is the same pattern as the existing clock-enable generator, with an added clear on accept.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Single byte:** reset, then `data_in`=0xA5 with a one-cycle `valid`. `tx` must be 0,1,0,1,0,0,1,0,1,1, with each bit lasting 4 cycles. `ready` must be low for exactly 40 cycles.
- **Parity:** with `UART_TX_PARITY_EN`, 0xA5 must give parity bit 0 and 0x07 must give parity bit 1. The frame must be 44 cycles.
- **Back-to-back:** hold `valid` with 0x00 then 0xFF. There must be exactly one idle `tx`=1 cycle between the stop bit of 0x00 and the start bit of 0xFF.
- **Busy ignore:** pulse `valid` with 0x3C in the middle of a 0x81 frame. The 0x81 frame must be unchanged, and no 0x3C frame may follow.
- **Data stability:** change `data_in` every cycle after accepting 0x5A. The serialized bits must match 0x5A.
- **Reset mid-frame:** assert `rst` during data bit 3. On the next cycle the outputs must read `tx`=1, `ready`=1 and `busy`=0. A new byte 0x12 sent afterward must serialize correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic LINE_IDLE      = 1'b1;
  localparam logic LINE_START     = 1'b0;
  localparam logic LINE_STOP      = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: one-cycle o_bit_done pulse every CLKS_PER_BIT cycles,
// restarted from zero by i_clear and after each pulse.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done     = (r_cnt == LAST);
  assign o_bit_done = w_done;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || w_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with valid/ready input; 8N1 by default,
// 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [UART_DATA_BITS-1:0] i_data_in,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy
);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_next;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [2:0]                r_bit_idx;
  logic                      w_tx;
  logic                      w_ready;
  logic                      w_accept;
  logic                      w_bit_done;
  logic                      w_last_bit;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  assign w_accept   = i_valid && w_ready;
  assign w_last_bit = (r_bit_idx == 3'(UART_DATA_BITS - 1));

  // Timer is held cleared while idle, so bit timing starts at the accept edge.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (r_state == IDLE),
    .o_bit_done(w_bit_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shreg   <= i_data_in;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^i_data_in;
`endif
      end else if (r_state == DATA && w_bit_done) begin
        r_shreg   <= {1'b0, r_shreg[UART_DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_tx    = LINE_IDLE;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_valid) w_next = START;
      end
      START: begin
        w_tx = LINE_START;
        if (w_bit_done) w_next = DATA;
      end
      DATA: begin
        w_tx = r_shreg[0];
        if (w_bit_done && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_parity;
        if (w_bit_done) w_next = STOP;
      end
`endif
      STOP: begin
        w_tx = LINE_STOP;
        if (w_bit_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_tx    = w_tx;
  assign o_ready = w_ready;
  assign o_busy  = ~w_ready;

endmodule
